pc_sequencer: RTL and testbench

Fetch-side PC sequencer that sits directly upstream of the register file's PC port. Each cycle it reads the current PC back from the register file and drives the next PC into it. It fetches 16-bit words from instruction memory and presents a registered IF/ID instruction to decode. It also loads the 32-bit PC from reset and interrupt vectors held in two consecutive memory words, high word first.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer_if_id_reg.sv | 33 +++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_W              = 32;
    localparam int unsigned INSTR_W           = 16;
    localparam int unsigned RESET_VEC_DEFAULT = 0;
    localparam int unsigned INT_VEC_DEFAULT   = 2;

    typedef enum logic [2:0] {
        S_VEC_HI = 3'd0,
        S_VEC_LO = 3'd1,
        S_RUN    = 3'd2,
        S_INT_HI = 3'd3,
        S_INT_LO = 3'd4
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Register-file, instruction-memory, EX redirect and decode signals of the PC sequencer.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_W,
    parameter int unsigned INSTR_WIDTH = INSTR_W
);

    logic [PC_WIDTH-1:0]    read_pc;
    logic [PC_WIDTH-1:0]    write_pc_data;
    logic                   pc_en;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic                   stall;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   int_req;
    logic                   int_ack;
    logic [PC_WIDTH-1:0]    saved_pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   instr_valid;

    modport master (
        input  read_pc, imem_data, stall, branch_taken, branch_target, int_req,
        output write_pc_data, pc_en, imem_addr, int_ack, saved_pc, instr, instr_pc, instr_valid
    );

    modport slave (
        output read_pc, imem_data, stall, branch_taken, branch_target, int_req,
        input  write_pc_data, pc_en, imem_addr, int_ack, saved_pc, instr, instr_pc, instr_valid
    );

endinterface

// File: rtl/pc_sequencer_if_id_reg.sv
// IF/ID pipeline register; flush clears valid, hold freezes all fields.
module if_id_reg
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_W,
    parameter int unsigned INSTR_WIDTH = INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] d_instr,
    input  logic [PC_WIDTH-1:0]    d_pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (!hold) begin
            instr       <= d_instr;
            instr_pc    <= d_pc;
            instr_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: vector loads, sequential fetch, branch redirect and interrupt entry.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned         PC_WIDTH       = PC_W,
    parameter int unsigned         INSTR_WIDTH    = INSTR_W,
    parameter logic [PC_WIDTH-1:0] RESET_VEC_ADDR = PC_WIDTH'(RESET_VEC_DEFAULT),
    parameter logic [PC_WIDTH-1:0] INT_VEC_ADDR   = PC_WIDTH'(INT_VEC_DEFAULT)
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    state_t                 state, state_nxt;
    logic [INSTR_WIDTH-1:0] vec_hi, vec_hi_nxt;
    logic                   int_pend, int_pend_nxt;
    logic                   int_ack, int_ack_nxt;
    logic [PC_WIDTH-1:0]    saved_pc, saved_pc_nxt;
    logic [PC_WIDTH-1:0]    write_pc, imem_addr;
    logic                   hold, flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_VEC_HI;
            vec_hi   <= '0;
            int_pend <= 1'b0;
            int_ack  <= 1'b0;
            saved_pc <= '0;
        end else begin
            state    <= state_nxt;
            vec_hi   <= vec_hi_nxt;
            int_pend <= int_pend_nxt;
            int_ack  <= int_ack_nxt;
            saved_pc <= saved_pc_nxt;
        end
    end

    // A new request always sets int_pend, even in the cycle that services the previous one.
    always_comb begin
        state_nxt    = state;
        vec_hi_nxt   = vec_hi;
        int_pend_nxt = int_pend | bus.int_req;
        int_ack_nxt  = 1'b0;
        saved_pc_nxt = saved_pc;
        write_pc     = bus.read_pc;
        imem_addr    = bus.read_pc;
        hold         = 1'b0;
        flush        = 1'b0;
        case (state)
            S_VEC_HI: begin
                imem_addr  = RESET_VEC_ADDR;
                vec_hi_nxt = bus.imem_data;
                flush      = 1'b1;
                state_nxt  = S_VEC_LO;
            end
            S_VEC_LO: begin
                imem_addr = RESET_VEC_ADDR + PC_WIDTH'(1);
                write_pc  = PC_WIDTH'({vec_hi, bus.imem_data});
                flush     = 1'b1;
                state_nxt = S_RUN;
            end
            S_INT_HI: begin
                imem_addr  = INT_VEC_ADDR;
                vec_hi_nxt = bus.imem_data;
                flush      = 1'b1;
                state_nxt  = S_INT_LO;
            end
            S_INT_LO: begin
                imem_addr = INT_VEC_ADDR + PC_WIDTH'(1);
                write_pc  = PC_WIDTH'({vec_hi, bus.imem_data});
                flush     = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.branch_taken) begin
                    write_pc = bus.branch_target;
                    flush    = 1'b1;
                end else if (bus.stall) begin
                    hold = 1'b1;
                end else if (int_pend) begin
                    saved_pc_nxt = bus.read_pc;
                    int_ack_nxt  = 1'b1;
                    int_pend_nxt = bus.int_req;
                    flush        = 1'b1;
                    state_nxt    = S_INT_HI;
                end else begin
                    write_pc = bus.read_pc + PC_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = S_VEC_HI;
            end
        endcase
        if (!rst) begin
            write_pc  = '0;
            imem_addr = RESET_VEC_ADDR;
        end
    end

    if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .flush       (flush),
        .d_instr     (bus.imem_data),
        .d_pc        (bus.read_pc),
        .instr       (bus.instr),
        .instr_pc    (bus.instr_pc),
        .instr_valid (bus.instr_valid)
    );

    assign bus.write_pc_data = write_pc;
    assign bus.imem_addr     = imem_addr;
    assign bus.pc_en         = 1'b0;
    assign bus.int_ack       = int_ack;
    assign bus.saved_pc      = saved_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a register-file PC model and a small instruction memory.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] vec_mem [4];
    logic [31:0] rf_pc;
    int          passed = 0;
    int          total  = 0;

    // Register file PC: stores write_pc_data every cycle (pc_en is never asserted).
    always @(posedge clk or negedge rst) begin
        if (!rst) rf_pc <= '0;
        else      rf_pc <= bus.write_pc_data;
    end
    assign bus.read_pc = rf_pc;

    // Vector table in words 0..3, elsewhere each word is its address XOR 0xA5A5.
    always_comb begin
        if (bus.imem_addr < 32'd4) bus.imem_data = vec_mem[bus.imem_addr[1:0]];
        else                       bus.imem_data = bus.imem_addr[15:0] ^ 16'hA5A5;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        vec_mem[0] = 16'h0000;
        vec_mem[1] = 16'h0020;
        vec_mem[2] = 16'h0001;
        vec_mem[3] = 16'h0000;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.int_req       = 1'b0;

        #12;
        check("rst_int_ack", 32'(bus.int_ack), 32'd0);
        check("rst_saved_pc", bus.saved_pc, 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_wpc", bus.write_pc_data, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        check("pc_en", 32'(bus.pc_en), 32'd0);

        // Reset vector load
        @(negedge clk); rst = 1'b1; #1;
        check("vhi_addr", bus.imem_addr, 32'd0);
        check("vhi_wpc", bus.write_pc_data, 32'd0);
        tick;
        check("vlo_addr", bus.imem_addr, 32'd1);
        check("vlo_wpc", bus.write_pc_data, 32'h20);
        tick;
        check("run0_addr", bus.imem_addr, 32'h20);
        check("run0_wpc", bus.write_pc_data, 32'h21);
        check("run0_valid", 32'(bus.instr_valid), 32'd0);
        tick;
        check("f20_valid", 32'(bus.instr_valid), 32'd1);
        check("f20_pc", bus.instr_pc, 32'h20);
        check("f20_instr", 32'(bus.instr), 32'hA585);

        // Sequential fetch then two stall cycles
        tick;
        check("f21_pc", bus.instr_pc, 32'h21);
        tick;
        check("f22_pc", bus.instr_pc, 32'h22);
        check("f22_instr", 32'(bus.instr), 32'hA587);
        bus.stall = 1'b1; #1;
        check("stall1_wpc", bus.write_pc_data, 32'h23);
        tick;
        check("stall1_pc", bus.instr_pc, 32'h22);
        check("stall1_valid", 32'(bus.instr_valid), 32'd1);
        check("stall2_wpc", bus.write_pc_data, 32'h23);
        tick;
        bus.stall = 1'b0; #1;
        check("stall2_pc", bus.instr_pc, 32'h22);
        check("unstall_addr", bus.imem_addr, 32'h23);
        check("unstall_wpc", bus.write_pc_data, 32'h24);
        tick;
        check("f23_pc", bus.instr_pc, 32'h23);

        // Branch flush at PC 0x24
        bus.branch_taken = 1'b1; bus.branch_target = 32'h100; #1;
        check("br_wpc", bus.write_pc_data, 32'h100);
        tick;
        bus.branch_taken = 1'b0; #1;
        check("br_flush", 32'(bus.instr_valid), 32'd0);
        check("br_addr", bus.imem_addr, 32'h100);
        tick;
        check("f100_valid", 32'(bus.instr_valid), 32'd1);
        check("f100_pc", bus.instr_pc, 32'h100);
        check("f100_instr", 32'(bus.instr), 32'hA4A5);

        // Interrupt taken at PC 0x30
        bus.branch_taken = 1'b1; bus.branch_target = 32'h2F;
        tick;
        bus.branch_taken = 1'b0; bus.int_req = 1'b1; #1;
        check("pre_int_wpc", bus.write_pc_data, 32'h30);
        tick;
        bus.int_req = 1'b0; #1;
        check("f2f_pc", bus.instr_pc, 32'h2F);
        check("f2f_instr", 32'(bus.instr), 32'hA58A);
        check("acc_wpc", bus.write_pc_data, 32'h30);
        check("acc_ack", 32'(bus.int_ack), 32'd0);
        tick;
        check("ihi_ack", 32'(bus.int_ack), 32'd1);
        check("ihi_saved", bus.saved_pc, 32'h30);
        check("ihi_addr", bus.imem_addr, 32'd2);
        check("ihi_valid", 32'(bus.instr_valid), 32'd0);
        check("ihi_wpc", bus.write_pc_data, 32'h30);
        tick;
        check("ilo_ack", 32'(bus.int_ack), 32'd0);
        check("ilo_addr", bus.imem_addr, 32'd3);
        check("ilo_wpc", bus.write_pc_data, 32'h0001_0000);
        tick;
        check("isr_addr", bus.imem_addr, 32'h0001_0000);
        check("isr_wpc", bus.write_pc_data, 32'h0001_0001);

        // Interrupt and branch together, followed by a stall
        bus.branch_taken = 1'b1; bus.branch_target = 32'h80; bus.int_req = 1'b1;
        tick;
        bus.branch_taken = 1'b0; bus.int_req = 1'b0; bus.stall = 1'b1; #1;
        check("ib_wpc", bus.write_pc_data, 32'h80);
        check("ib_flush", 32'(bus.instr_valid), 32'd0);
        tick;
        bus.stall = 1'b0; #1;
        check("ib_stall_ack", 32'(bus.int_ack), 32'd0);
        check("ib_acc_wpc", bus.write_pc_data, 32'h80);
        tick;
        check("ib_ack", 32'(bus.int_ack), 32'd1);
        check("ib_saved", bus.saved_pc, 32'h80);
        bus.int_req = 1'b1;
        tick;
        bus.int_req = 1'b0; #1;
        check("ib_ack_pulse", 32'(bus.int_ack), 32'd0);
        tick;
        // Request seen during the vector load is serviced at once; a new one arrives here too
        bus.int_req = 1'b1; #1;
        check("vpend_wpc", bus.write_pc_data, 32'h0001_0000);
        check("vpend_valid", 32'(bus.instr_valid), 32'd0);
        tick;
        bus.int_req = 1'b0; #1;
        check("vpend_ack", 32'(bus.int_ack), 32'd1);
        check("vpend_saved", bus.saved_pc, 32'h0001_0000);
        tick;
        tick;
        check("sc_ack_low", 32'(bus.int_ack), 32'd0);
        check("sc_wpc", bus.write_pc_data, 32'h0001_0000);
        tick;
        check("sc_ack", 32'(bus.int_ack), 32'd1);
        tick;
        tick;
        check("sc_done_wpc", bus.write_pc_data, 32'h0001_0001);

        // Vector 0xFFFFFFFF wraps to 0
        vec_mem[2] = 16'hFFFF; vec_mem[3] = 16'hFFFF; bus.int_req = 1'b1;
        tick;
        bus.int_req = 1'b0;
        tick;
        tick;
        check("wrap_vec_wpc", bus.write_pc_data, 32'hFFFF_FFFF);
        tick;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFF);
        check("wrap_wpc", bus.write_pc_data, 32'h0);
        tick;
        check("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFF);
        check("wrap_instr", 32'(bus.instr), 32'h5A5A);
        check("wrap_next_wpc", bus.write_pc_data, 32'h1);
        bus.int_req = 1'b1;
        tick;
        bus.int_req = 1'b0;
        tick;
        check("w_ack", 32'(bus.int_ack), 32'd1);
        check("w_saved", bus.saved_pc, 32'h1);
        tick;
        check("w_ilo_addr", bus.imem_addr, 32'd3);

        // Asynchronous reset in the middle of S_INT_LO
        rst = 1'b0; #1;
        check("ar_ack", 32'(bus.int_ack), 32'd0);
        check("ar_saved", bus.saved_pc, 32'd0);
        check("ar_valid", 32'(bus.instr_valid), 32'd0);
        check("ar_instr_pc", bus.instr_pc, 32'd0);
        check("ar_wpc", bus.write_pc_data, 32'd0);
        check("ar_addr", bus.imem_addr, 32'd0);
        @(negedge clk); rst = 1'b1; #1;
        check("rr_vhi_addr", bus.imem_addr, 32'd0);
        tick;
        check("rr_vlo_addr", bus.imem_addr, 32'd1);
        check("rr_vlo_wpc", bus.write_pc_data, 32'h20);
        tick;
        check("rr_run_addr", bus.imem_addr, 32'h20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
